// File: rtl/io_supply_pkg.sv
// Shared types and sizing helpers for the IO supply-domain sequencer.
// Imported by io_supply_seq.
package io_supply_pkg;

   typedef enum logic [2:0] {
      DOWN,
      RAMP_UP,
      SETTLE_UP,
      UP,
      ISO_DN,
      RAMP_DN,
      FAULT
   } seq_state_e;

   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int cnt_w(input int s, input int t, input int d);
      int m;
      m = s;
      if (t > m) m = t;
      if (d > m) m = d;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/io_supply_seq.sv
// N-domain IO supply sequencer: ordered power-up/down, isolation gating,
// power-good timeout checking and sticky fault latching.
module io_supply_seq
   import io_supply_pkg::*;
#(
   parameter int N_DOM       = 3,
   parameter int SETTLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 16,
   parameter int DOWN_CYC    = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      pwr_req,
   input  logic [N_DOM-1:0]          pgood,
   input  logic                      fault_clr,
   output logic [N_DOM-1:0]          dom_en,
   output logic [N_DOM-1:0]          dom_iso,
   output logic                      all_up,
   output logic                      all_down,
   output logic                      busy,
   output logic                      fault,
   output logic [idx_w(N_DOM)-1:0]   fault_dom
);

   localparam int IDXW = idx_w(N_DOM);
   localparam int CW   = cnt_w(SETTLE_CYC, TIMEOUT_CYC, DOWN_CYC);

   localparam logic [IDXW-1:0] LAST  = IDXW'(N_DOM - 1);
   localparam logic [CW-1:0]   SET_M = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0]   TO_M  = CW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0]   DN_M  = CW'(DOWN_CYC - 1);

   seq_state_e       state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N_DOM-1:0] en_q, en_d;
   logic [N_DOM-1:0] iso_q, iso_d;
   logic             fault_q, fault_d;
   logic [IDXW-1:0]  fdom_q, fdom_d;
   logic             up_q, up_d;
   logic             dn_q, dn_d;
   logic             busy_q, busy_d;

   logic             any_bad;
   logic [IDXW-1:0]  low_bad;
   logic [IDXW-1:0]  idx_inc;

   assign idx_inc = idx_q + 1'b1;

   // Lowest enabled domain that lost power-good.
   always_comb begin
      any_bad = 1'b0;
      low_bad = '0;
      for (int i = N_DOM - 1; i >= 0; i--) begin
         if (en_q[i] && !pgood[i]) begin
            any_bad = 1'b1;
            low_bad = IDXW'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      iso_d   = iso_q;
      fault_d = fault_q;
      fdom_d  = fdom_q;

      unique case (state_q)
         DOWN: begin
            if (pwr_req && !fault_q) begin
               en_d[0] = 1'b1;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = RAMP_UP;
            end
         end
         RAMP_UP: begin
            cnt_d = cnt_q + 1'b1;
            if (!pgood[idx_q] && cnt_q == TO_M) begin
               state_d = FAULT;
               en_d    = '0;
               iso_d   = '1;
               fault_d = 1'b1;
               fdom_d  = idx_q;
            end else if (!pwr_req) begin
               state_d = ISO_DN;
            end else if (pgood[idx_q]) begin
               cnt_d   = '0;
               state_d = SETTLE_UP;
            end
         end
         SETTLE_UP: begin
            if (!pgood[idx_q]) begin
               state_d = FAULT;
               en_d    = '0;
               iso_d   = '1;
               fault_d = 1'b1;
               fdom_d  = idx_q;
            end else if (!pwr_req) begin
               state_d = ISO_DN;
            end else if (cnt_q == SET_M) begin
               iso_d[idx_q] = 1'b0;
               if (idx_q == LAST) begin
                  state_d = UP;
               end else begin
                  idx_d         = idx_inc;
                  en_d[idx_inc] = 1'b1;
                  cnt_d         = '0;
                  state_d       = RAMP_UP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         UP: begin
            // A supply loss outranks a simultaneous power-down request.
            if (any_bad) begin
               state_d = FAULT;
               en_d    = '0;
               iso_d   = '1;
               fault_d = 1'b1;
               fdom_d  = low_bad;
            end else if (!pwr_req) begin
               idx_d   = LAST;
               state_d = ISO_DN;
            end
         end
         ISO_DN: begin
            iso_d[idx_q] = 1'b1;
            cnt_d        = '0;
            state_d      = RAMP_DN;
         end
         RAMP_DN: begin
            if (cnt_q == DN_M) begin
               en_d[idx_q] = 1'b0;
               if (idx_q == '0) begin
                  state_d = DOWN;
               end else begin
                  idx_d   = idx_q - 1'b1;
                  state_d = ISO_DN;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FAULT: begin
            if (fault_clr && !pwr_req) begin
               fault_d = 1'b0;
               state_d = DOWN;
            end
         end
         default: state_d = DOWN;
      endcase

      up_d   = (state_d == UP);
      dn_d   = (state_d == DOWN);
      busy_d = (state_d == RAMP_UP) || (state_d == SETTLE_UP) ||
               (state_d == ISO_DN)  || (state_d == RAMP_DN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DOWN;
         idx_q   <= '0;
         cnt_q   <= '0;
         en_q    <= '0;
         iso_q   <= '1;
         fault_q <= 1'b0;
         fdom_q  <= '0;
         up_q    <= 1'b0;
         dn_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         iso_q   <= iso_d;
         fault_q <= fault_d;
         fdom_q  <= fdom_d;
         up_q    <= up_d;
         dn_q    <= dn_d;
         busy_q  <= busy_d;
      end
   end

   // A de-isolated domain must always be powered.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (&(iso_q | en_q))
            else $error("de-isolated domain without enable");
      end
   end

   assign dom_en    = en_q;
   assign dom_iso   = iso_q;
   assign all_up    = up_q;
   assign all_down  = dn_q;
   assign busy      = busy_q;
   assign fault     = fault_q;
   assign fault_dom = fdom_q;

endmodule

// File: doc/io_supply_seq.md
Name: io_supply_seq

Overview:
- Parametrised N-domain IO supply sequencer for the pad ring. It generalises the passive supply/well pad (VDDIO/VDD/VPW) into an actively sequenced set of switchable IO supply domains.
- Powers domains up in ascending index order and down in descending order. Gates each domain's isolation, checks power-good with a timeout, and latches faults.
- Sits between the always-on power controller (pwr_req) and the pad-ring supply switches and isolation cells.

Parameters:
- N_DOM, 3, number of sequenced supply domains (1..16)
- SETTLE_CYC, 4, cycles pgood must be held before a domain's isolation is released (>=1)
- TIMEOUT_CYC, 16, max cycles from dom_en rise to pgood rise before fault (>=2)
- DOWN_CYC, 3, cycles between iso assert and en deassert on power-down, and between domains (>=1)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- pwr_req  in  1  level request: 1 = all domains up, 0 = all down
- pgood  in  N_DOM  per-domain power-good from the supply monitor, synchronous to clk
- fault_clr  in  1  pulse; clears a latched fault
- dom_en  out  N_DOM  supply switch enable per domain
- dom_iso  out  N_DOM  isolation enable per domain (1 = isolated)
- all_up  out  1  all domains enabled and de-isolated
- all_down  out  1  all domains disabled and isolated
- busy  out  1  sequencing in progress
- fault  out  1  sticky fault flag
- fault_dom  out  IDXW  index of the faulting domain, IDXW = max(1, clog2(N_DOM))

Behaviour:
- All outputs are registered.
- Reset values: dom_en=0, dom_iso=all 1, all_down=1, all_up=0, busy=0, fault=0, fault_dom=0, state=DOWN, idx=0, cnt=0.
- A single counter cnt is sized to clog2(max(SETTLE_CYC, TIMEOUT_CYC, DOWN_CYC)+1). Domain index idx is IDXW bits.

FSM states: DOWN, RAMP_UP, SETTLE_UP, UP, ISO_DN, RAMP_DN, FAULT.
- DOWN:
  - If pwr_req=1 and !fault: set dom_en[0]=1, idx=0, cnt=0, go to RAMP_UP.
  - all_down=1.
- RAMP_UP:
  - cnt increments each cycle.
  - If pgood[idx]=1: cnt=0, go to SETTLE_UP.
  - Else if cnt==TIMEOUT_CYC-1: go to FAULT with fault_dom=idx.
- SETTLE_UP:
  - If pgood[idx] drops: go to FAULT, fault_dom=idx.
  - When cnt==SETTLE_CYC-1: clear dom_iso[idx].
    - If idx==N_DOM-1: go to UP.
    - Else in the same edge: idx++, set dom_en[idx+1]=1, cnt=0, go to RAMP_UP.
- UP:
  - all_up=1.
  - If any pgood[i]=0 for an enabled domain: go to FAULT, fault_dom = lowest such i.
  - If pwr_req=0: go to ISO_DN with idx=N_DOM-1.
- ISO_DN:
  - Set dom_iso[idx]=1, cnt=0, go to RAMP_DN.
- RAMP_DN:
  - After DOWN_CYC cycles, clear dom_en[idx].
    - If idx==0: go to DOWN.
    - Else: idx--, go to ISO_DN.
  - pgood is ignored during power-down.
- pwr_req drop during RAMP_UP/SETTLE_UP:
  - Abort immediately: go to ISO_DN with idx = the current domain.
  - The partially-up domain is isolated and disabled first, then the lower ones.
- pwr_req rise during ISO_DN/RAMP_DN:
  - Ignored; power-down completes to DOWN.
  - A new power-up starts on the next cycle if pwr_req is still 1.
- FAULT:
  - On entry edge: dom_iso=all 1 and dom_en=0 simultaneously; fault=1; busy=0.
  - Stays in FAULT until fault_clr=1 and pwr_req=0, then fault=0 and go to DOWN.
  - fault_clr while pwr_req=1 is ignored.
- busy=1 in RAMP_UP, SETTLE_UP, ISO_DN, RAMP_DN.
- all_up and all_down are never both 1.
- Simultaneous pgood loss and pwr_req drop in UP: the fault has priority.
- Invariant (assert in RTL and bench): dom_iso[i]=0 implies dom_en[i]=1.
- rst mid-sequence returns every output to its reset value on the next edge. Downstream switches rely on this.

Decomposition:
- Package io_supply_pkg holds:
  - the state enum seq_state_e {DOWN, RAMP_UP, SETTLE_UP, UP, ISO_DN, RAMP_DN, FAULT}
  - the IDXW function
  - the cnt width function
- No sub-module is needed. One FSM, one counter and one index register keep the block in the 150–250 line range.

Test Plan:
- N_DOM=3, SETTLE=4, TIMEOUT=16; bench drives pgood[i] high 2 edges after dom_en[i] rises; pwr_req=1 before edge 1.
  - dom_en[0] rises after edge 1, dom_en[1] after edge 7, dom_en[2] after edge 13.
  - dom_iso[2] clears and all_up=1 after edge 19.
- From UP, pwr_req=0.
  - Domain 2 isolated, then disabled DOWN_CYC=3 edges later; then domain 1; then domain 0.
  - all_down=1 after 12 edges.
  - Invariant holds throughout.
- pgood[1] held low: fault=1, fault_dom=1 at edge 7+16, with dom_en=000 and dom_iso=111 on the same edge.
  - fault_clr with pwr_req=1 is ignored.
  - fault_clr with pwr_req=0 returns the block to DOWN.
- In UP, drop pgood[0] for 1 cycle: FAULT with fault_dom=0, even with pwr_req falling on the same cycle.
- pwr_req drops during SETTLE_UP of domain 1: domain 1 is isolated and disabled, then domain 0.
  - pwr_req re-rises during RAMP_DN: power-down completes to DOWN, then a fresh power-up starts.
- rst asserted during RAMP_UP of domain 2: next edge gives dom_en=000, dom_iso=111, all_down=1, fault=0.
